// File: rtl/ga_serial_pkg.sv
// Shared definitions for the GA result serial framer: frame states, sync byte,
// error pad width and the payload-length helper.
package ga_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN,
        PAYLOAD,
        CSUM,
        FIN
    } frameState_t;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         ERROR_PAD_WIDTH = 16;

    // Payload bytes: padded error, generation counter, best individual.
    function automatic int payloadLen(input int counterWidth, input int individualWidth);
        return ERROR_PAD_WIDTH / 8 + counterWidth / 8 + individualWidth / 8;
    endfunction

endpackage

// File: rtl/ga_result_framer_if.sv
// Byte stream towards the serial TX path: valid/ready handshake with one data byte.
interface ga_result_framer_if;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;

    modport master (output txData, output txValid, input txReady);
    modport slave  (input txData, input txValid, output txReady);
endinterface

// File: rtl/byte_shift_out.sv
// Snapshot register that presents its top byte and shifts left by one byte per
// accepted transfer, so bytes leave MSB-first.
module byte_shift_out #(
    parameter int Width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] loadData,
    input  logic             shift,
    output logic [7:0]       curByte
);

    logic [Width-1:0] shiftReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shiftReg <= '0;
        end else if (load) begin
            shiftReg <= loadData;
        end else if (shift) begin
            shiftReg <= {shiftReg[Width-9:0], 8'h00};
        end
    end

    assign curByte = shiftReg[Width-1 -: 8];

endmodule

// File: rtl/ga_result_framer.sv
// Snapshots the GA result on a rising start level and streams it as a framed byte
// sequence. Define GA_RESULT_FRAMER_CHECKSUM_EN to append an XOR checksum byte.
module ga_result_framer
    import ga_serial_pkg::*;
#(
    parameter int         ErrorWidth      = 5,
    parameter int         CounterWidth    = 16,
    parameter int         IndividualWidth = 32,
    parameter logic [7:0] SyncByte        = SYNC_BYTE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ErrorWidth-1:0]      bestError,
    input  logic [CounterWidth-1:0]    counter,
    input  logic [IndividualWidth-1:0] bestIndividual,
    ga_result_framer_if.master         tx,
    output logic                       busy,
    output logic                       done
);

    localparam int ShadowWidth = ERROR_PAD_WIDTH + CounterWidth + IndividualWidth;
    localparam int PayloadLen  = payloadLen(CounterWidth, IndividualWidth);
    localparam int IndexWidth  = $clog2(PayloadLen + 1);
    localparam logic [7:0]            LenByte   = 8'(PayloadLen);
    localparam logic [IndexWidth-1:0] LastIndex = IndexWidth'(PayloadLen - 1);

    frameState_t            stateReg, stateNext;
    logic                   armReg;
    logic [IndexWidth-1:0]  indexReg;
    logic                   capture;
    logic                   xfer;
    logic                   shiftEn;
    logic [7:0]             curByte;
    logic [ShadowWidth-1:0] snapshot;

    assign snapshot = {ERROR_PAD_WIDTH'(bestError), counter, bestIndividual};
    assign capture  = (stateReg == IDLE) && start && armReg;
    assign xfer     = tx.txValid && tx.txReady;
    assign shiftEn  = xfer && (stateReg == PAYLOAD);

    byte_shift_out #(
        .Width(ShadowWidth)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (capture),
        .loadData (snapshot),
        .shift    (shiftEn),
        .curByte  (curByte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // A held start must be seen low in IDLE before it can trigger another frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armReg   <= 1'b0;
            indexReg <= '0;
        end else begin
            if (capture) begin
                armReg   <= 1'b0;
                indexReg <= '0;
            end else if ((stateReg == IDLE) && !start) begin
                armReg <= 1'b1;
            end
            if (shiftEn) begin
                indexReg <= indexReg + IndexWidth'(1);
            end
        end
    end

`ifdef GA_RESULT_FRAMER_CHECKSUM_EN
    logic [7:0] csumReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csumReg <= 8'h00;
        end else if (capture) begin
            csumReg <= 8'h00;
        end else if (shiftEn) begin
            csumReg <= csumReg ^ curByte;
        end
    end
`endif

    always_comb begin
        stateNext  = stateReg;
        tx.txValid = 1'b0;
        tx.txData  = 8'h00;
        busy       = 1'b1;
        done       = 1'b0;
        case (stateReg)
            IDLE: begin
                busy = 1'b0;
                if (capture) stateNext = SYNC;
            end
            SYNC: begin
                tx.txValid = 1'b1;
                tx.txData  = SyncByte;
                if (tx.txReady) stateNext = LEN;
            end
            LEN: begin
                tx.txValid = 1'b1;
                tx.txData  = LenByte;
                if (tx.txReady) stateNext = PAYLOAD;
            end
            PAYLOAD: begin
                tx.txValid = 1'b1;
                tx.txData  = curByte;
                if (tx.txReady && (indexReg == LastIndex)) begin
`ifdef GA_RESULT_FRAMER_CHECKSUM_EN
                    stateNext = CSUM;
`else
                    stateNext = FIN;
`endif
                end
            end
`ifdef GA_RESULT_FRAMER_CHECKSUM_EN
            CSUM: begin
                tx.txValid = 1'b1;
                tx.txData  = csumReg;
                if (tx.txReady) stateNext = FIN;
            end
`endif
            FIN: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ga_result_framer.sv
// Directed bench for ga_result_framer: a byte scoreboard filled when frames are
// requested and drained by a monitor on every accepted byte.
module tb_ga_result_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  bestError = '0;
    logic [15:0] counter = '0;
    logic [31:0] bestIndividual = '0;
    logic        busy;
    logic        done;

    ga_result_framer_if bus ();

`ifdef GA_RESULT_FRAMER_CHECKSUM_EN
    localparam int FrameLen = 11;
`else
    localparam int FrameLen = 10;
`endif

    int         checks = 0;
    int         errors = 0;
    int         doneCount = 0;
    logic [7:0] expQ[$];
    logic       prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;

    always #5 clk = ~clk;

    ga_result_framer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bestError      (bestError),
        .counter        (counter),
        .bestIndividual (bestIndividual),
        .tx             (bus),
        .busy           (busy),
        .done           (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pushFrame(input logic [4:0] e, input logic [15:0] c, input logic [31:0] ind);
        logic [7:0] p [8];
`ifdef GA_RESULT_FRAMER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        p = '{8'h00, {3'b000, e}, c[15:8], c[7:0], ind[31:24], ind[23:16], ind[15:8], ind[7:0]};
        expQ.push_back(8'hA5);
        expQ.push_back(8'h08);
        for (int i = 0; i < 8; i++) begin
            expQ.push_back(p[i]);
`ifdef GA_RESULT_FRAMER_CHECKSUM_EN
            x = x ^ p[i];
`endif
        end
`ifdef GA_RESULT_FRAMER_CHECKSUM_EN
        expQ.push_back(x);
`endif
    endtask

    task automatic waitDone(input string tag, input int budget, input bit randomReady);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (randomReady) bus.txReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        bus.txReady = 1'b1;
    endtask

    // Monitor: each accepted byte is popped from the scoreboard; stalled bytes must hold.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (!rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                check("stall_valid", 32'(bus.txValid), 32'd1);
                check("stall_data", 32'(bus.txData), 32'(prevData));
            end
            if (bus.txValid && bus.txReady) begin
                if (expQ.size() == 0) begin
                    check("unexpected_byte", 32'(bus.txData), 32'hFFFF_FFFF);
                end else begin
                    exp = expQ.pop_front();
                    check("tx_byte", 32'(bus.txData), 32'(exp));
                end
            end
            if (done) doneCount++;
            prevStall = bus.txValid && !bus.txReady;
            prevData  = bus.txData;
        end
    end

    initial begin
        int d0;
        bus.txReady = 1'b1;

        // Reset state
        #2;
        check("rst_txValid", 32'(bus.txValid), 32'd0);
        check("rst_txData", 32'(bus.txData), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame with txReady held high: back-to-back bytes then done
        bestError = 5'd3;
        counter = 16'h0124;
        bestIndividual = 32'hDEADBEEF;
        pushFrame(bestError, counter, bestIndividual);
        d0 = doneCount;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < FrameLen; k++) begin
            @(negedge clk);
            check("frame_valid", 32'(bus.txValid), 32'd1);
            check("frame_busy", 32'(busy), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("done_cleared", 32'(done), 32'd0);
        check("busy_cleared", 32'(busy), 32'd0);
        check("done_once", 32'(doneCount - d0), 32'd1);
        check("basic_drained", 32'(expQ.size()), 32'd0);

        // Level start held high: no retrigger
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("no_retrigger", 32'(doneCount - d0), 32'd1);
        check("idle_valid", 32'(bus.txValid), 32'd0);

        // Start low then high: second frame, with backpressure and a start pulse mid-frame
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        bus.txReady = 1'b0;
        pushFrame(bestError, counter, bestIndividual);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone("bp_done", 400, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("two_frames", 32'(doneCount - d0), 32'd2);
        check("bp_drained", 32'(expQ.size()), 32'd0);

        // Inputs change after the LEN byte: frame keeps the snapshot
        @(posedge clk);
        #1;
        bus.txReady = 1'b1;
        pushFrame(bestError, counter, bestIndividual);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        counter = 16'hFFFF;
        bestError = 5'd0;
        bestIndividual = 32'h0;
        waitDone("change_done", 100, 1'b0);
        start = 1'b0;
        check("change_drained", 32'(expQ.size()), 32'd0);

        // Reset during the 5th byte
        repeat (2) @(posedge clk);
        #1;
        bestError = 5'h1F;
        counter = 16'hBEEF;
        bestIndividual = 32'h12345678;
        pushFrame(bestError, counter, bestIndividual);
        start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_txValid", 32'(bus.txValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        expQ.delete();
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        pushFrame(bestError, counter, bestIndividual);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("resync_sync", 32'(bus.txData), 32'hA5);
        waitDone("resync_done", 100, 1'b0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        check("final_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ga_result_framer.md
Name: ga_result_framer

Overview:
- Downstream stage of the morphologic GA debug top. When the GA finishes, it snapshots the GA result (best error, generation counter, best individual) into a shadow register.
- It then streams that snapshot as a framed byte sequence into the serial TX byte path, using a valid/ready handshake.
- It decouples the GA result from serial throughput and adds framing that the host uses for resynchronisation.

Parameters:
- ErrorWidth, 5, width of bestError; must be ≤16 (zero-padded to 16 bits on the wire).
- CounterWidth, 16, width of the generation counter; must be a multiple of 8.
- IndividualWidth, 32, width of bestIndividual; must be a multiple of 8.
- SyncByte, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level request to send a frame; typically driven by the GA finish signal.
- bestError  in  ErrorWidth  GA best error.
- counter  in  CounterWidth  generation count.
- bestIndividual  in  IndividualWidth  GA best individual.
- txReady  in  1  downstream can accept a byte (driven as ~txBusy).
- txData  out  8  current byte.
- txValid  out  1  txData is valid.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Payload length PL = 2 + CounterWidth/8 + IndividualWidth/8; PL = 8 with default parameters.
- Frame layout: SyncByte, PL[7:0], payload bytes MSB-first, then an optional checksum byte.
- Payload order: error zero-extended to 16 bits, then counter, then individual.
- FSM states: IDLE, SYNC, LEN, PAYLOAD, CSUM, FIN.
- IDLE: arm flag is set while start=0.
  - If start=1 and arm=1 on an edge: capture {error16, counter, individual} into the shadow register, clear arm and the byte index, and go to SYNC.
  - start held high never retriggers; it must drop to 0 before the next frame.
- Byte transfer rule: a byte transfers on an edge where txValid=1 and txReady=1.
  - txData and txValid stay stable until the transfer.
  - txValid is never withdrawn without a transfer, except on reset.
- SYNC: txData=SyncByte; on transfer, go to LEN.
- LEN: txData=PL; on transfer, go to PAYLOAD.
- PAYLOAD: txData = shadow byte[index], where index 0 is the MSB.
  - On transfer, index increments.
  - At index PL-1, go to CSUM if the checksum is enabled, otherwise FIN.
- CSUM: txData = accumulated checksum; on transfer, go to FIN.
- FIN: txValid=0; done=1 for exactly one cycle; then return to IDLE.
- Latency: start is seen at edge N, and txValid=1 with SyncByte from edge N onward.
  - With txReady held at 1, the frame occupies PL+2 (or PL+3 with checksum) consecutive cycles, and done follows on the next cycle.
- busy=1 in every state except IDLE.
- Inputs change while busy: no effect on the frame in progress, because the snapshot is already captured.
- Reset values (async, while rst=0): state=IDLE, txValid=0, txData=0, busy=0, done=0, arm=0, shadow=0, index=0.
  - Reset mid-frame aborts immediately and truncates the frame; the host resyncs on SyncByte.
- After reset release, start must be seen low for at least one edge before the first frame (arm starts at 0).

Optional Feature:
- Macro: GA_RESULT_FRAMER_CHECKSUM_EN.
- Defined: CSUM state is present. Checksum = XOR of all payload bytes, excluding sync and length. It accumulates on each PAYLOAD transfer and clears at capture. Frame length is PL+3 bytes.
- Undefined: no CSUM state and no checksum register. PAYLOAD goes directly to FIN. Frame length is PL+2 bytes.
- The length byte equals PL in both builds.

Decomposition:
- Shared package ga_serial_pkg holds:
  - the state enum/localparams;
  - SYNC_BYTE;
  - a function computing PL from CounterWidth and IndividualWidth;
  - the 16-bit error pad width.
- One natural sub-module, byte_shift_out: it loads the shadow register and shifts out MSB-first bytes on transfer, exposing the current byte. Checksum logic stays in the top.

Test Plan:
- Basic frame, checksum enabled, txReady=1:
  - Stimulus: error=3, counter=16'h0124, individual=32'hDEADBEEF; start raised.
  - Required bytes: A5 08 00 03 01 24 DE AD BE EF 04, on 11 consecutive cycles.
  - done pulses once, and busy falls with it.
- Backpressure: same data, txReady toggling pseudo-randomly.
  - Byte sequence identical to the basic case.
  - txData stable whenever txValid=1 and txReady=0.
- Level start: start held high for 100 cycles, then low, then high.
  - Exactly two frames are sent.
  - A start pulse during a frame is ignored.
- Input change mid-frame: counter changes to 16'hFFFF after the LEN byte.
  - Payload still carries 01 24.
- Reset mid-frame: rst=0 during the 5th byte.
  - txValid, busy and done go to 0 asynchronously.
  - After release with start low then high, a complete fresh frame starts with A5.
- Checksum disabled build, same data as the basic frame:
  - Required bytes: A5 08 00 03 01 24 DE AD BE EF, 10 bytes.
  - done pulses on the cycle after EF transfers.
